// File: rtl/pl_hazard_scoreboard_pkg.sv
// Shared constants for the pipeline hazard / forwarding unit.
// Forward-select encodings driven to the E-stage operand muxes.
// Default register-file geometry.
package pl_hazard_scoreboard_pkg;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_WB   = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;

    localparam int NREGS_DEF = 32;
    localparam int RA_W_DEF  = 5;

endpackage

// File: rtl/pl_hazard_scoreboard_sb.sv
// Pending-write scoreboard for long-latency results, one bit per register.
// Latency: set/clear masks take effect at the next clock edge.
// Set wins over clear on the same register; register 0 is never pending.
module pl_hazard_scoreboard_sb #(
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREGS-1:0] set_i,
    input  logic [NREGS-1:0] clr_i,
    output logic [NREGS-1:0] pending_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // next state: clear retiring writes, then apply new issues so set dominates
    always_comb begin
        pending_d    = (pending_q & ~clr_i) | set_i;
        pending_d[0] = 1'b0;
    end

    // scoreboard register, synchronously cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/pl_hazard_scoreboard.sv
// Hazard/forwarding unit: E-stage forward selects plus F/D/E stall and flush.
// Combinational outputs; scoreboard bits appear one cycle after issue, clears bypass same cycle.
// Optional perf counters under HAZARD_PERF_EN; otherwise the counter ports read zero.
module pl_hazard_scoreboard
    import pl_hazard_scoreboard_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int RA_W   = $clog2(NREGS),
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   rs1_d,
    input  logic [RA_W-1:0]   rs2_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic [RA_W-1:0]   rd_d,
    input  logic              reg_write_d,
    input  logic              long_op_d,
    input  logic              lu_busy,
    input  logic              lu_done,
    input  logic [RA_W-1:0]   lu_rd,
    input  logic [RA_W-1:0]   rs1_e,
    input  logic [RA_W-1:0]   rs2_e,
    input  logic [RA_W-1:0]   rd_e,
    input  logic              reg_write_e,
    input  logic              load_e,
    input  logic              branch_taken_e,
    input  logic [RA_W-1:0]   rd_m,
    input  logic              reg_write_m,
    input  logic [RA_W-1:0]   rd_w,
    input  logic              reg_write_w,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [NREGS-1:0]  pending,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
);

    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] pend_eff;
    logic             load_use;
    logic             sb_raw;
    logic             sb_waw;
    logic             lu_struct;
    logic             hold;

    // operand forwarding: the younger M result beats W, x0 is never forwarded
    always_comb begin
        forward_a_e = FWD_NONE;
        forward_b_e = FWD_NONE;
        if (!rst) begin
            if (reg_write_m && rd_m != '0 && rs1_e == rd_m) begin
                forward_a_e = FWD_MEM;
            end else if (reg_write_w && rd_w != '0 && rs1_e == rd_w) begin
                forward_a_e = FWD_WB;
            end
            if (reg_write_m && rd_m != '0 && rs2_e == rd_m) begin
                forward_b_e = FWD_MEM;
            end else if (reg_write_w && rd_w != '0 && rs2_e == rd_w) begin
                forward_b_e = FWD_WB;
            end
        end
    end

    // hazard detection; a long-unit write landing this cycle already unblocks readers
    always_comb begin
        clr_mask  = (lu_done && lu_rd != '0 && !rst) ? (NREGS'(1) << lu_rd) : '0;
        pend_eff  = pending & ~clr_mask;
        load_use  = load_e && reg_write_e && rd_e != '0 &&
                    ((use_rs1_d && rs1_d == rd_e) || (use_rs2_d && rs2_d == rd_e));
        sb_raw    = (use_rs1_d && pend_eff[rs1_d]) || (use_rs2_d && pend_eff[rs2_d]);
        sb_waw    = reg_write_d && rd_d != '0 && pend_eff[rd_d];
        lu_struct = long_op_d && lu_busy;
        hold      = load_use || sb_raw || sb_waw || lu_struct;
    end

    // stall/flush: reset and taken branches flush D/E and release any stall
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b1;
        flush_e = 1'b1;
        if (!rst && !branch_taken_e) begin
            stall_f = hold;
            stall_d = hold;
            flush_d = 1'b0;
            flush_e = hold;
        end
    end

    // a long op marks its destination only when it actually leaves D
    always_comb begin
        set_mask = '0;
        if (long_op_d && reg_write_d && rd_d != '0 && !stall_d && !flush_e) begin
            set_mask = NREGS'(1) << rd_d;
        end
    end

    pl_hazard_scoreboard_sb #(
        .NREGS (NREGS)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_i     (set_mask),
        .clr_i     (clr_mask),
        .pending_o (pending)
    );

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q;
    logic [PERF_W-1:0] flush_cnt_d;

    // saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_d && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
        if (branch_taken_e && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    // counter registers, synchronously cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pl_hazard_scoreboard.sv
// Self-checking bench for pl_hazard_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
// Model tracks outstanding long-unit destinations as a plain bit array.
module tb_pl_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rd_d, lu_rd, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       use_rs1_d, use_rs2_d, reg_write_d, long_op_d, lu_busy, lu_done;
    logic       reg_write_e, load_e, branch_taken_e, reg_write_m, reg_write_w;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic [31:0] pending;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    int total = 0;
    int bad   = 0;

    pl_hazard_scoreboard dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .rd_d(rd_d), .reg_write_d(reg_write_d), .long_op_d(long_op_d),
        .lu_busy(lu_busy), .lu_done(lu_done), .lu_rd(lu_rd),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
        .load_e(load_e), .branch_taken_e(branch_taken_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .pending(pending), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    bit mpend [32];
    int m_stall_cnt;
    int m_flush_cnt;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sf;
        logic       sd;
        logic       fd;
        logic       fe;
    } exp_t;

    // register blocks a reader/writer if still outstanding and not retiring right now
    function automatic bit still_busy(input int r);
        if (r == 0) return 1'b0;
        if (lu_done && int'(lu_rd) == r) return 1'b0;
        return mpend[r];
    endfunction

    function automatic logic [1:0] fwd_pick(input int r);
        if (r == 0) return 2'd0;
        if (reg_write_m && int'(rd_m) == r) return 2'd2;
        if (reg_write_w && int'(rd_w) == r) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit must_wait();
        bit w = 1'b0;
        if (load_e && reg_write_e && rd_e != 0) begin
            if (use_rs1_d && rs1_d == rd_e) w = 1'b1;
            if (use_rs2_d && rs2_d == rd_e) w = 1'b1;
        end
        if (use_rs1_d && still_busy(int'(rs1_d))) w = 1'b1;
        if (use_rs2_d && still_busy(int'(rs2_d))) w = 1'b1;
        if (reg_write_d && still_busy(int'(rd_d))) w = 1'b1;
        if (long_op_d && lu_busy) w = 1'b1;
        return w;
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        if (rst) begin
            e = '{fa: 2'd0, fb: 2'd0, sf: 1'b0, sd: 1'b0, fd: 1'b1, fe: 1'b1};
        end else if (branch_taken_e) begin
            e = '{fa: fwd_pick(int'(rs1_e)), fb: fwd_pick(int'(rs2_e)),
                  sf: 1'b0, sd: 1'b0, fd: 1'b1, fe: 1'b1};
        end else begin
            bit w = must_wait();
            e = '{fa: fwd_pick(int'(rs1_e)), fb: fwd_pick(int'(rs2_e)),
                  sf: w, sd: w, fd: 1'b0, fe: w};
        end
        return e;
    endfunction

    function automatic logic [31:0] model_pend_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = mpend[i];
        return v;
    endfunction

    // model state advance at each rising edge
    always @(posedge clk) begin
        exp_t e;
        e = model_eval();
        if (rst) begin
            for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (lu_done) mpend[lu_rd] = 1'b0;
            if (long_op_d && reg_write_d && rd_d != 0 && !branch_taken_e && !e.sd)
                mpend[rd_d] = 1'b1;
            if (e.sd) m_stall_cnt++;
            if (branch_taken_e) m_flush_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model, away from the rising edge
    always @(negedge clk) begin
        exp_t e;
        e = model_eval();
        chk("fwd_a", 64'(forward_a_e), 64'(e.fa));
        chk("fwd_b", 64'(forward_b_e), 64'(e.fb));
        chk("stall_f", 64'(stall_f), 64'(e.sf));
        chk("stall_d", 64'(stall_d), 64'(e.sd));
        chk("flush_d", 64'(flush_d), 64'(e.fd));
        chk("flush_e", 64'(flush_e), 64'(e.fe));
        chk("pending", 64'(pending), 64'(model_pend_vec()));
`ifdef HAZARD_PERF_EN
        chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stall_cnt));
        chk("perf_flush", 64'(perf_flush_cnt), 64'(m_flush_cnt));
`else
        chk("perf_stall", 64'(perf_stall_cnt), 64'd0);
        chk("perf_flush", 64'(perf_flush_cnt), 64'd0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        {rs1_d, rs2_d, rd_d, lu_rd, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {use_rs1_d, use_rs2_d, reg_write_d, long_op_d, lu_busy, lu_done} = '0;
        {reg_write_e, load_e, branch_taken_e, reg_write_m, reg_write_w} = '0;
    endtask

    // advance to just after the next rising edge with idle inputs
    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;

        // reset: forwards suppressed, D/E flushed, nothing pending
        next_cycle();
        reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5;
        load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd6; use_rs1_d = 1'b1; rs1_d = 5'd6;
        #2;
        chk("rst_fwd", 64'(forward_a_e), 64'd0);
        chk("rst_stall", 64'(stall_f), 64'd0);
        chk("rst_flush", 64'({flush_d, flush_e}), 64'h3);
        chk("rst_pend", 64'(pending), 64'd0);
        next_cycle();
        rst = 1'b0;

        // forwarding priority and x0
        next_cycle();
        reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5;
        #2 chk("fwd_m", 64'(forward_a_e), 64'd2);
        reg_write_w = 1'b1; rd_w = 5'd5;
        #1 chk("fwd_m_over_w", 64'(forward_a_e), 64'd2);
        reg_write_m = 1'b0; rs2_e = 5'd5;
        #1 chk("fwd_w_b", 64'(forward_b_e), 64'd1);
        rs1_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0; reg_write_m = 1'b1;
        #1 chk("fwd_x0", 64'(forward_a_e), 64'd0);

        // load-use
        next_cycle();
        load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd6; use_rs1_d = 1'b1; rs1_d = 5'd6;
        #2 chk("ld_use", 64'({stall_f, stall_d, flush_e, flush_d}), 64'b1110);
        use_rs1_d = 1'b0; rs2_d = 5'd6;
        #1 chk("ld_unused", 64'(stall_d), 64'd0);

        // mul x7 issue, RAW stall until lu_done bypass, WAW, structural
        next_cycle();
        long_op_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd7;
        next_cycle();
        #2 chk("mul_pend", 64'(pending[7]), 64'd1);
        use_rs1_d = 1'b1; rs1_d = 5'd7;
        #1 chk("raw_stall", 64'(stall_d), 64'd1);
        next_cycle();
        reg_write_d = 1'b1; rd_d = 5'd7;
        #2 chk("waw_stall", 64'(stall_d), 64'd1);
        next_cycle();
        long_op_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd8; lu_busy = 1'b1;
        #2 chk("struct_stall", 64'(stall_d), 64'd1);
        next_cycle();
        #2 chk("struct_noset", 64'(pending[8]), 64'd0);
        use_rs1_d = 1'b1; rs1_d = 5'd7; lu_done = 1'b1; lu_rd = 5'd7;
        #1 chk("raw_bypass", 64'(stall_d), 64'd0);
        next_cycle();
        #2 chk("pend_cleared", 64'(pending[7]), 64'd0);

        // branch overrides load-use and blocks issue
        load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd6; use_rs1_d = 1'b1; rs1_d = 5'd6;
        branch_taken_e = 1'b1; long_op_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd10;
        #1 chk("br_ctl", 64'({stall_f, flush_d, flush_e}), 64'b011);
        next_cycle();
        #2 chk("br_noset", 64'(pending[10]), 64'd0);

        // same-cycle clear and reissue of x9: set wins
        long_op_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd9;
        next_cycle();
        long_op_d = 1'b1; reg_write_d = 1'b1; rd_d = 5'd9; lu_done = 1'b1; lu_rd = 5'd9;
        #2 chk("reissue_nostall", 64'(stall_d), 64'd0);
        next_cycle();
        #2 chk("set_wins", 64'(pending[9]), 64'd1);

        // reset in the middle of a stall
        use_rs1_d = 1'b1; rs1_d = 5'd9; rst = 1'b1;
        #1 chk("rst_mid", 64'({stall_d, flush_d, flush_e}), 64'b011);
        next_cycle();
        #2 chk("rst_mid_pend", 64'(pending), 64'd0);
        next_cycle();
        rst = 1'b0;

        // randomized traffic, small register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rst            = ($urandom_range(0, 99) == 0);
            rs1_d          = 5'($urandom_range(0, 7));
            rs2_d          = 5'($urandom_range(0, 7));
            rd_d           = 5'($urandom_range(0, 7));
            use_rs1_d      = 1'($urandom_range(0, 1));
            use_rs2_d      = 1'($urandom_range(0, 1));
            reg_write_d    = ($urandom_range(0, 3) != 0);
            long_op_d      = ($urandom_range(0, 2) == 0);
            lu_busy        = ($urandom_range(0, 3) == 0);
            lu_done        = ($urandom_range(0, 2) == 0);
            lu_rd          = 5'($urandom_range(0, 7));
            rs1_e          = 5'($urandom_range(0, 7));
            rs2_e          = 5'($urandom_range(0, 7));
            rd_e           = 5'($urandom_range(0, 7));
            reg_write_e    = 1'($urandom_range(0, 1));
            load_e         = ($urandom_range(0, 2) == 0);
            branch_taken_e = ($urandom_range(0, 7) == 0);
            rd_m           = 5'($urandom_range(0, 7));
            reg_write_m    = 1'($urandom_range(0, 1));
            rd_w           = 5'($urandom_range(0, 7));
            reg_write_w    = 1'($urandom_range(0, 1));
        end

        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
